ysyx_23060201_ifu: RTL



---
 rtl/ysyx_23060201_ifu_pkg.sv | 23 ++
 rtl/ysyx_23060201_ifu_fsm.sv | 72 +++++++
 rtl/ysyx_23060201_ifu.sv | 102 ++++++++++
 3 files changed

// File: rtl/ysyx_23060201_ifu_pkg.sv
// Shared IFU definitions: reset PC, fault-cause codes and FSM state encodings.
// Imported by the IFU top level and its FSM sub-module.
package ysyx_23060201_ifu_pkg;

  localparam logic [31:0] YSYX_23060201_RESET_PC = 32'h8000_0000;
  localparam int          TMO_W                  = 16;

  typedef enum logic [1:0] {
    IFERR_NONE     = 2'b00,
    IFERR_MISALIGN = 2'b01,
    IFERR_BUS      = 2'b10,
    IFERR_TIMEOUT  = 2'b11
  } iferr_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_EXEC = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060201_ifu_fsm.sv
// IFU control: state register, next-state selection and the memory response
// timeout counter. timeout_hit flags the WAIT cycle that gives up on the bus.
module ysyx_23060201_ifu_fsm
  import ysyx_23060201_ifu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pc_misaligned,
  input  logic       mem_req_ready,
  input  logic       mem_resp_valid,
  input  logic       inst_ready,
  input  logic       commit_valid,
  output ifu_state_e state,
  output logic       timeout_hit
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  ifu_state_e       state_reg, state_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;

  assign state       = state_reg;
  assign timeout_hit = (state_reg == ST_WAIT) && !mem_resp_valid && (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    state_next   = state_reg;
    tmo_cnt_next = tmo_cnt_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        // A misaligned PC never reaches the bus; it faults straight to OUT.
        if (pc_misaligned) begin
          state_next = ST_OUT;
        end else if (mem_req_ready) begin
          state_next   = ST_WAIT;
          tmo_cnt_next = '0;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid || timeout_hit) begin
          state_next = ST_OUT;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      ST_OUT: begin
        if (inst_ready) begin
          state_next = commit_valid ? ST_REQ : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (commit_valid) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end

endmodule

// File: rtl/ysyx_23060201_ifu.sv
// Multi-cycle instruction fetch unit: holds the PC, fetches one word at a time
// and hands it to the decoder, then waits for the EXU's dnpc commit.
module ysyx_23060201_ifu
  import ysyx_23060201_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = YSYX_23060201_RESET_PC,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  inst_err,
  input  logic        commit_valid,
  input  logic [31:0] dnpc,
  output logic [31:0] fetch_cnt
);

  ifu_state_e  state;
  logic        timeout_hit;
  logic        pc_misaligned;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  iferr_e      err_reg;
  logic [31:0] fetch_cnt_reg;

  assign pc_misaligned = |pc_reg[1:0];

  ysyx_23060201_ifu_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .pc_misaligned (pc_misaligned),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .inst_ready    (inst_ready),
    .commit_valid  (commit_valid),
    .state         (state),
    .timeout_hit   (timeout_hit)
  );

  // Outputs come only from registers and state, never straight from inputs.
  assign mem_req_valid = (state == ST_REQ) && !pc_misaligned;
  assign mem_req_addr  = pc_reg;
  assign inst_valid    = (state == ST_OUT);
  assign inst          = inst_reg;
  assign inst_pc       = pc_reg;
  assign inst_err      = err_reg;
  assign fetch_cnt     = fetch_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      inst_reg      <= '0;
      err_reg       <= IFERR_NONE;
      fetch_cnt_reg <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (pc_misaligned) begin
            inst_reg <= '0;
            err_reg  <= IFERR_MISALIGN;
          end
        end
        ST_WAIT: begin
          // Faulted words are zeroed so the decoder never sees bus garbage.
          if (mem_resp_valid) begin
            inst_reg <= mem_resp_err ? 32'h0 : mem_resp_data;
            err_reg  <= mem_resp_err ? IFERR_BUS : IFERR_NONE;
          end else if (timeout_hit) begin
            inst_reg <= '0;
            err_reg  <= IFERR_TIMEOUT;
          end
        end
        ST_OUT: begin
          if (inst_ready) begin
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            if (commit_valid) begin
              pc_reg <= dnpc;
            end
          end
        end
        ST_EXEC: begin
          if (commit_valid) begin
            pc_reg <= dnpc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
